// File: rtl/if_pkg.sv
// Shared constants for the MIPS instruction fetch stage.
// Optional feature macro used across the slice: IF_BRANCH_EN.
package if_pkg;

    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 32;
    localparam int ADDR_W    = 5;
    localparam int PC_STEP   = 4;

    localparam logic [DATA_W-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

    // The memory is word addressed, so the two byte-offset bits are dropped
    // and everything above the memory size is ignored (fetch wraps).
    function automatic logic [ADDR_W-1:0] word_index(input logic [DATA_W-1:0] pc);
        return pc[ADDR_W+1:2];
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bus between the fetch stage and its environment (ID stage / loader).
// The branch redirect signals exist only when IF_BRANCH_EN is defined.
interface instruction_fetch_if;
    import if_pkg::*;

    logic              stall;
    logic              load_mem_en;
    logic [DATA_W-1:0] load_mem_data;
    logic [ADDR_W-1:0] load_mem_addr;
`ifdef IF_BRANCH_EN
    logic              branch_taken;
    logic [DATA_W-1:0] branch_target;
`endif
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc_out;

    // Environment side: drives control and load data, observes the fetch result.
    modport master (
        output stall, load_mem_en, load_mem_data, load_mem_addr,
`ifdef IF_BRANCH_EN
        output branch_taken, branch_target,
`endif
        input  instr, pc_out
    );

    // Fetch stage side.
    modport slave (
        input  stall, load_mem_en, load_mem_data, load_mem_addr,
`ifdef IF_BRANCH_EN
        input  branch_taken, branch_target,
`endif
        output instr, pc_out
    );

endinterface

// File: rtl/instr_mem.sv
// Instruction memory: synchronous write, asynchronous read, and a
// synchronous clear of every word to NOP while reset is held.
module instr_mem
    import if_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // Reset wipes the whole array so execution starts on NOPs; loads are ignored during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= NOP_INSTR;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage MIPS pipeline: PC register, next-PC selection and
// the instruction memory. Defining IF_BRANCH_EN adds a branch redirect input.
module instruction_fetch
    import if_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    instruction_fetch_if.slave  bus
);

    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] next_pc;
    logic [DATA_W-1:0] rdata;

    // Next PC: loading holds the PC, a taken branch beats a stall, otherwise step by one word.
    always_comb begin
        next_pc = pc + DATA_W'(PC_STEP);
        if (bus.load_mem_en) begin
            next_pc = pc;
        end
`ifdef IF_BRANCH_EN
        else if (bus.branch_taken) begin
            next_pc = {bus.branch_target[DATA_W-1:2], 2'b00};
        end
`endif
        else if (bus.stall) begin
            next_pc = pc;
        end
    end

    // PC register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    instr_mem u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (bus.load_mem_en),
        .waddr (bus.load_mem_addr),
        .wdata (bus.load_mem_data),
        .raddr (word_index(pc)),
        .rdata (rdata)
    );

    assign bus.instr  = rdata;
    assign bus.pc_out = pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a vector table, hand-written
// corner-case sequences and a randomized phase against a reference model.
// Branch checks are compiled in when IF_BRANCH_EN is defined.
module tb_instruction_fetch;

    logic clk = 1'b0;
    logic rst;

    instruction_fetch_if bus ();

    instruction_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state: plain array plus a PC number.
    logic [31:0] model_mem [32];
    logic [31:0] model_pc;

    typedef struct {
        logic        r;
        logic        s;
        logic        le;
        logic [31:0] d;
        logic [4:0]  a;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [31:0] modelInstr();
        return model_mem[(model_pc / 4) % 32];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model on the edge, then compare against it.
    task automatic applyStimulus(input logic r, input logic s, input logic le,
                                 input logic [31:0] d, input logic [4:0] a,
                                 input logic bt, input logic [31:0] tgt);
        rst               = r;
        bus.stall         = s;
        bus.load_mem_en   = le;
        bus.load_mem_data = d;
        bus.load_mem_addr = a;
`ifdef IF_BRANCH_EN
        bus.branch_taken  = bt;
        bus.branch_target = tgt;
`endif
        @(posedge clk);
        if (r) begin
            model_pc = 32'h0;
            for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
        end else if (le) begin
            model_mem[a] = d;
        end else if (bt) begin
            model_pc = tgt & 32'hFFFF_FFFC;
        end else if (!s) begin
            model_pc = model_pc + 32'd4;
        end
        #1;
        checkOutput("model_pc", bus.pc_out, model_pc);
        checkOutput("model_instr", bus.instr, modelInstr());
    endtask

    task automatic runCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    endtask

    task automatic loadRamp();
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'hA000_0000 + 32'(i), 5'(i), 1'b0, 32'h0);
            checkOutput("load_pc_hold", bus.pc_out, 32'h0);
        end
    endtask

    initial begin
        rst               = 1'b1;
        bus.stall         = 1'b0;
        bus.load_mem_en   = 1'b0;
        bus.load_mem_data = 32'h0;
        bus.load_mem_addr = 5'd0;
`ifdef IF_BRANCH_EN
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
`endif
        model_pc = 32'h0;
        for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;

        // Table: reset, run, reset, load into current word, load+stall, stall, run.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,  5'd0, 32'h0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,  5'd0, 32'h0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,  5'd0, 32'h4, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,  5'd0, 32'h8, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,  5'd0, 32'hC, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,  5'd0, 32'h0, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h11, 5'd0, 32'h0, 32'h11};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h22, 5'd1, 32'h0, 32'h11};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,  5'd0, 32'h0, 32'h11};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,  5'd0, 32'h4, 32'h22};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,  5'd0, 32'h8, 32'h0};

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].r, vecs[i].s, vecs[i].le, vecs[i].d, vecs[i].a, 1'b0, 32'h0);
            checkOutput($sformatf("vec%0d_pc", i), bus.pc_out, vecs[i].exp_pc);
            checkOutput($sformatf("vec%0d_instr", i), bus.instr, vecs[i].exp_instr);
        end

        // Long reset then free run.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
            checkOutput("reset_pc", bus.pc_out, 32'h0);
            checkOutput("reset_instr", bus.instr, 32'h0);
        end
        for (int k = 1; k <= 4; k++) begin
            runCycle();
            checkOutput("run_pc", bus.pc_out, 32'(4 * k));
        end

        // Program full memory, then run past the 128-byte wrap.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        loadRamp();
        checkOutput("first_instr", bus.instr, 32'hA000_0000);
        for (int k = 1; k <= 33; k++) begin
            runCycle();
            checkOutput("seq_pc", bus.pc_out, 32'(4 * k));
            checkOutput("seq_instr", bus.instr, 32'hA000_0000 + 32'(k % 32));
        end
        checkOutput("wrap_pc", bus.pc_out, 32'h84);

        // Stall at 0x10.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        loadRamp();
        for (int k = 0; k < 4; k++) runCycle();
        checkOutput("pre_stall_pc", bus.pc_out, 32'h10);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
            checkOutput("stall_pc", bus.pc_out, 32'h10);
            checkOutput("stall_instr", bus.instr, 32'hA000_0004);
        end
        runCycle();
        checkOutput("unstall_pc", bus.pc_out, 32'h14);
        checkOutput("unstall_instr", bus.instr, 32'hA000_0005);

        // Overwrite the word currently being fetched.
        bus.load_mem_en   = 1'b1;
        bus.load_mem_addr = 5'd5;
        bus.load_mem_data = 32'hDEAD_BEEF;
        #1;
        checkOutput("overwrite_old", bus.instr, 32'hA000_0005);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 5'd5, 1'b0, 32'h0);
        checkOutput("overwrite_pc", bus.pc_out, 32'h14);
        checkOutput("overwrite_new", bus.instr, 32'hDEAD_BEEF);
        runCycle();
        checkOutput("after_overwrite", bus.instr, 32'hA000_0006);

        // Reset while loading: write suppressed, memory cleared.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h1234_5678, 5'd3, 1'b0, 32'h0);
        checkOutput("rst_load_pc", bus.pc_out, 32'h0);
        checkOutput("rst_load_instr", bus.instr, 32'h0);
        for (int k = 0; k < 3; k++) runCycle();
        checkOutput("rst_load_word3_pc", bus.pc_out, 32'hC);
        checkOutput("rst_load_word3", bus.instr, 32'h0);

`ifdef IF_BRANCH_EN
        // Branch overrides stall; low target bits dropped; loading blocks the branch.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hB16B_00B5, 5'd16, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 5'd0, 1'b1, 32'h40);
        checkOutput("branch_load_hold", bus.pc_out, 32'hC);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 1'b1, 32'h43);
        checkOutput("branch_pc", bus.pc_out, 32'h40);
        checkOutput("branch_instr", bus.instr, 32'hB16B_00B5);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 500; n++) begin
            logic r, s, le, bt;
            r  = ($urandom_range(0, 39) == 0);
            s  = ($urandom_range(0, 3) == 0);
            le = ($urandom_range(0, 3) == 0);
`ifdef IF_BRANCH_EN
            bt = ($urandom_range(0, 5) == 0);
`else
            bt = 1'b0;
`endif
            applyStimulus(r, s, le, $urandom, 5'($urandom_range(0, 31)), bt, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
